mux_arb_nx24: RTL and testbench
===============================

Name: mux_arb_nx24

Overview:
- Parametrised N-input, WIDTH-bit registered multiplexer with valid/ready handshakes; successor to the plain 2:1 24-bit datapath mux.
- Two modes:
  - Direct mode: an explicit select picks the source.
  - Round-robin mode: fair arbitration among requesting sources.
- Holds one registered output word. Sits between multiple producers (ALU result, memory read, immediate path, I/O) and a single consumer stage in the 24-bit CPU datapath.

Parameters:
- WIDTH, 24, data width of each channel.
- NUM_IN, 4, number of input channels (2..16).
- SEL_W, 2, select width; must equal ceil(log2(NUM_IN)).

Ports:
- Clock  input  1  single system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- InValid  input  NUM_IN  per-channel request; bit i belongs to channel i.
- InData  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- InReady  output  NUM_IN  one-hot (or zero) accept strobe per channel.
- Mode  input  1  0 = direct select, 1 = round-robin.
- Sel  input  SEL_W  channel index used in direct mode.
- OutValid  output  1  output register holds a valid word.
- OutData  output  WIDTH  registered data word.
- OutSrc  output  SEL_W  index of the channel that supplied OutData.
- OutReady  input  1  consumer accepts the word when OutValid=1.

Behaviour:
- Reset is sampled only on a rising Clock edge. After reset:
  - OutValid=0, OutData=0, OutSrc=0.
  - Round-robin pointer Last=NUM_IN-1, so channel 0 has first priority.
  - InReady=0 while Reset=1.
- Load enable: LoadEn = !OutValid | OutReady (register empty or draining this cycle). Throughput is one word per cycle; latency is one cycle from input accept to OutValid.
- Grant (combinational, evaluated only when LoadEn=1):
  - Mode 0: grant channel Sel iff InValid[Sel]=1 and Sel<NUM_IN. Sel >= NUM_IN gives no grant.
  - Mode 1: grant the first channel with InValid=1, searching Last+1, Last+2, ... and wrapping modulo NUM_IN.
  - No request: no grant.
- InReady[g]=1 only for the granted channel g and only when LoadEn=1; all other bits are 0. A transfer on channel i occurs when InValid[i] & InReady[i].
- On a clock edge with a grant g:
  - OutData <= InData[g], OutSrc <= g, OutValid <= 1.
  - In mode 1, Last <= g. In mode 0, Last is unchanged.
- On a clock edge with no grant and OutValid & OutReady: OutValid <= 0. OutData and OutSrc hold their last values.
- Backpressure: while OutValid=1 and OutReady=0, OutData, OutSrc and OutValid hold stable and InReady is all zero.
- Simultaneous drain and load: the word is accepted downstream and the new word is loaded in the same edge, giving no bubble.
- Mode and Sel may change on any cycle. They affect only the next grant decision and never alter a word already held.
- InReady is combinational from InValid, Mode, Sel, OutValid, OutReady. OutValid and OutData never depend combinationally on inputs.
- Reset mid-operation: a held word is discarded (OutValid=0 on the next edge) and the pointer returns to NUM_IN-1.
- Producers must hold InValid and InData stable until accepted. The block does not check this.

Test Plan:
- Reset: assert Reset 2 cycles with all InValid=1 and OutReady=1 -> InReady=0 during reset; OutValid=0, OutData=0, OutSrc=0 after the first edge.
- Direct mode: Mode=0, Sel=2, InValid=4'b1111, InData[2]=24'hABCDEF, OutReady=1 -> InReady=4'b0100; one edge later OutValid=1, OutData=24'hABCDEF, OutSrc=2. With Sel=1 and InValid[1]=0 -> InReady=0 and OutValid drops after the drain edge.
- Round-robin fairness: Mode=1, all four channels valid continuously, OutReady=1 -> OutSrc sequence 0,1,2,3,0,1 on consecutive cycles with OutValid held high.
- Backpressure: load channel 3 (24'h000123), then hold OutReady=0 for 5 cycles -> OutData stays 24'h000123 and OutSrc stays 3, InReady=0 throughout. On OutReady=1, the next grant loads in the same edge with no bubble cycle.
- Wrap and skip: Mode=1, Last=3, InValid=4'b1010 -> channel 1 is granted, then channel 3, then channel 1.
- Reset mid-operation: OutValid=1 holding 24'h555555 with OutReady=0, assert Reset one cycle -> OutValid=0 next edge. A following round-robin request on all channels grants channel 0 first.

Source files
------------

// File: rtl/mux_arb_nx24.sv
// mux_arb_nx24: N-input registered mux with direct-select or round-robin grant and valid/ready handshakes
module mux_arb_nx24 #(
    parameter int WIDTH  = 24,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_IN-1:0]       i_valid,
    input  logic [NUM_IN*WIDTH-1:0] i_data,
    output logic [NUM_IN-1:0]       o_ready,
    input  logic                    i_mode,
    input  logic [SEL_W-1:0]        i_sel,
    output logic                    o_valid,
    output logic [WIDTH-1:0]        o_data,
    output logic [SEL_W-1:0]        o_src,
    input  logic                    i_out_ready
);
    logic [SEL_W-1:0] r_last, w_rr_g, w_g;
    logic             w_load, w_rr_hit, w_dir_hit, w_grant;
    assign w_load    = !o_valid || i_out_ready;
    assign w_dir_hit = (int'(i_sel) < NUM_IN) && i_valid[i_sel];
    // descending scan so the nearest requester after r_last wins
    always_comb begin
        w_rr_hit = 1'b0;
        w_rr_g   = '0;
        for (int k = NUM_IN; k >= 1; k--) begin
            if (i_valid[SEL_W'((int'(r_last) + k) % NUM_IN)]) begin
                w_rr_hit = 1'b1;
                w_rr_g   = SEL_W'((int'(r_last) + k) % NUM_IN);
            end
        end
    end
    assign w_g     = i_mode ? w_rr_g : i_sel;
    assign w_grant = !i_rst && w_load && (i_mode ? w_rr_hit : w_dir_hit);
    assign o_ready = w_grant ? (NUM_IN'(1) << w_g) : '0;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_src   <= '0;
            r_last  <= SEL_W'(NUM_IN - 1);
        end else if (w_grant) begin
            o_valid <= 1'b1;
            o_data  <= i_data[int'(w_g)*WIDTH +: WIDTH];
            o_src   <= w_g;
            if (i_mode) r_last <= w_g;
        end else if (o_valid && i_out_ready) begin
            o_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mux_arb_nx24.sv
// tb_mux_arb_nx24: directed vectors with a queue scoreboard checked by an output monitor
module tb_mux_arb_nx24;
    logic        clk = 1'b0, rst, mode, out_ready, o_valid;
    logic [3:0]  valid, o_ready;
    logic [1:0]  sel, o_src;
    logic [23:0] o_data;
    logic [23:0] d [4];
    logic [95:0] data;
    logic [25:0] sb [$];
    int          n_chk = 0, n_fail = 0;

    assign data = {d[3], d[2], d[1], d[0]};
    always #5 clk = ~clk;

    mux_arb_nx24 dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data), .o_ready(o_ready),
        .i_mode(mode), .i_sel(sel), .o_valid(o_valid), .o_data(o_data), .o_src(o_src),
        .i_out_ready(out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one cycle of stimulus: check the accept strobe, log the expected word, advance
    task automatic step(input logic [3:0] v, input logic m, input logic [1:0] s, input logic r,
                        input logic [3:0] exp_rdy, input logic [23:0] exp_d, input logic [1:0] exp_s);
        valid = v; mode = m; sel = s; out_ready = r;
        #1;
        chk("in_ready", 32'(o_ready), 32'(exp_rdy));
        if (exp_rdy != 4'b0) sb.push_back({exp_s, exp_d});
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (!rst && o_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_out: got src %0d data %h expected nothing", o_src, o_data);
            end else begin
                logic [25:0] e;
                e = sb.pop_front();
                chk("out_word", {6'b0, o_src, o_data}, {6'b0, e});
            end
        end
    end

    initial begin
        d[0] = 24'h100000; d[1] = 24'h111111; d[2] = 24'hABCDEF; d[3] = 24'h000123;
        rst = 1'b1; valid = 4'hF; out_ready = 1'b1; mode = 1'b1; sel = 2'd0;
        #1;
        chk("rst_in_ready", 32'(o_ready), 0);
        @(posedge clk); #1;
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_data", 32'(o_data), 0);
        chk("rst_src", 32'(o_src), 0);
        chk("rst_in_ready2", 32'(o_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        // direct mode
        step(4'b1111, 0, 2, 1, 4'b0100, 24'hABCDEF, 2);
        chk("dir_valid", 32'(o_valid), 1);
        chk("dir_data", 32'(o_data), 32'h00ABCDEF);
        chk("dir_src", 32'(o_src), 2);
        step(4'b1101, 0, 1, 1, 4'b0000, 0, 0);
        chk("dir_drain", 32'(o_valid), 0);
        // round-robin fairness
        step(4'b1111, 1, 0, 1, 4'b0001, 24'h100000, 0);
        step(4'b1111, 1, 0, 1, 4'b0010, 24'h111111, 1);
        chk("rr_valid_hi", 32'(o_valid), 1);
        step(4'b1111, 1, 0, 1, 4'b0100, 24'hABCDEF, 2);
        step(4'b1111, 1, 0, 1, 4'b1000, 24'h000123, 3);
        step(4'b1111, 1, 0, 1, 4'b0001, 24'h100000, 0);
        step(4'b1111, 1, 0, 1, 4'b0010, 24'h111111, 1);
        chk("rr_valid_hi2", 32'(o_valid), 1);
        step(4'b0000, 1, 0, 1, 4'b0000, 0, 0);
        chk("rr_drain", 32'(o_valid), 0);
        // backpressure: direct load of channel 3 leaves the pointer at 1
        step(4'b1000, 0, 3, 1, 4'b1000, 24'h000123, 3);
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 1, 0, 0, 4'b0000, 0, 0);
            chk("bp_valid", 32'(o_valid), 1);
            chk("bp_data", 32'(o_data), 32'h000123);
            chk("bp_src", 32'(o_src), 3);
        end
        step(4'b1111, 1, 0, 1, 4'b0100, 24'hABCDEF, 2);
        chk("bp_nobubble_valid", 32'(o_valid), 1);
        chk("bp_nobubble_src", 32'(o_src), 2);
        // wrap and skip
        step(4'b1000, 1, 0, 1, 4'b1000, 24'h000123, 3);
        step(4'b1010, 1, 0, 1, 4'b0010, 24'h111111, 1);
        step(4'b1010, 1, 0, 1, 4'b1000, 24'h000123, 3);
        step(4'b1010, 1, 0, 1, 4'b0010, 24'h111111, 1);
        step(4'b0000, 1, 0, 1, 4'b0000, 0, 0);
        // reset mid-operation discards the held word
        d[1] = 24'h555555;
        step(4'b0010, 0, 1, 1, 4'b0010, 24'h555555, 1);
        step(4'b0000, 0, 0, 0, 4'b0000, 0, 0);
        chk("mid_hold", 32'(o_data), 32'h555555);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_valid", 32'(o_valid), 0);
        sb.delete();
        rst = 1'b0;
        step(4'b1111, 1, 0, 1, 4'b0001, 24'h100000, 0);
        step(4'b0000, 1, 0, 1, 4'b0000, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
